// File: rtl/a2d_spi_resp.sv
// A2D conversion responder: two 16-bit SPI frames (address, then read) to an 8-channel ADC.
// Latency: strt_cnv accepted at edge 0 -> cnv_cmplt at edge 1041+GAP_CLKS.
// Backpressure: none; strt_cnv is dropped while a conversion is in flight.
module a2d_spi_resp #(
    parameter int GAP_CLKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int              GW        = (GAP_CLKS < 1) ? 1 : $clog2(GAP_CLKS + 1);
    localparam logic [4:0]      SCLK_LOAD = 5'b10111;
    localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP_CLKS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FRAME1 = 3'd1,
        GAP    = 3'd2,
        FRAME2 = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [2:0]      ch_q;
    logic [15:0]     tx;
    logic [11:0]     rx;
    logic [4:0]      sclk_cnt;
    logic [4:0]      bit_cnt;
    logic [GW-1:0]   gap_cnt;

    logic            in_frame;
    logic            accept;
    logic            rise;
    logic            fall;
    logic            frame_end;
    logic            gap_done;

    always_comb begin
        in_frame  = (state == FRAME1) || (state == FRAME2);
        accept    = strt_cnv && ((state == IDLE) || (state == DONE));
        rise      = in_frame && (sclk_cnt == 5'b01111);
        fall      = in_frame && (sclk_cnt == 5'b11111);
        // After the 16th rise the frame closes as the counter reaches 11111,
        // so SCLK is left high and no trailing fall is generated.
        frame_end = in_frame && (bit_cnt == 5'd16) && (sclk_cnt == 5'b11110);
        gap_done  = (state == GAP) && (gap_cnt == GAP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = FRAME1;
            FRAME1:  if (frame_end) state_nxt = GAP;
            GAP:     if (gap_done)  state_nxt = FRAME2;
            FRAME2:  if (frame_end) state_nxt = DONE;
            DONE:    if (accept)    state_nxt = FRAME1;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q      <= 3'd0;
            tx        <= 16'h0000;
            rx        <= 12'h000;
            sclk_cnt  <= SCLK_LOAD;
            bit_cnt   <= 5'd0;
            gap_cnt   <= '0;
            cnv_cmplt <= 1'b0;
            res       <= 12'h000;
        end else begin
            if (accept) begin
                ch_q      <= chnnl;
                cnv_cmplt <= 1'b0;
                tx        <= {2'b00, chnnl, 11'h000};
                sclk_cnt  <= SCLK_LOAD;
                bit_cnt   <= 5'd0;
            end

            if (in_frame) begin
                sclk_cnt <= sclk_cnt + 5'd1;
                // Only the low 12 bits are kept; upper response bits fall off the end.
                if (rise) begin
                    rx      <= {rx[10:0], MISO};
                    bit_cnt <= bit_cnt + 5'd1;
                end
                // The opening fall precedes any rise and must not shift out the MSB.
                if (fall && (bit_cnt != 5'd0)) begin
                    tx <= {tx[14:0], 1'b0};
                end
            end

            if (frame_end) begin
                gap_cnt <= '0;
                if (state == FRAME2) begin
                    res       <= rx;
                    cnv_cmplt <= 1'b1;
                end
            end

            if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
                if (gap_done) begin
                    tx       <= {2'b00, ch_q, 11'h000};
                    sclk_cnt <= SCLK_LOAD;
                    bit_cnt  <= 5'd0;
                end
            end
        end
    end

    assign SS_n = ~in_frame;
    assign SCLK = ~in_frame | sclk_cnt[4];
    assign MOSI = in_frame & tx[15];

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: random conversions against an ADC word model and frame-level timing rules.
module tb_a2d_spi_resp;

    localparam int GAP       = 8;
    localparam int LAT       = 1041 + GAP;
    localparam int FRAME_LEN = 520;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl = 3'd0;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO = 1'b0;

    a2d_spi_resp #(.GAP_CLKS(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ADC side: one record per SS_n-low window
    typedef struct {
        int          start;
        int          stop;
        int          len;
        int          rises;
        logic [15:0] mosi;
    } frame_t;

    frame_t      frq[$];
    int          fcnt = 0;
    int          base = 0;
    logic [15:0] f1_word = 16'h0;
    logic [15:0] f2_word = 16'h0;

    logic        prev_ss = 1'b1;
    logic        prev_sclk = 1'b1;
    int          m_start = 0;
    int          m_len = 0;
    int          m_rises = 0;
    logic [15:0] m_mosi = 16'h0;
    logic [15:0] m_word = 16'h0;

    always @(negedge clk) begin
        if (!SS_n) begin
            if (prev_ss) begin
                m_start = cyc;
                m_len   = 0;
                m_rises = 0;
                m_mosi  = 16'h0;
                m_word  = (fcnt == base) ? f1_word : f2_word;
                fcnt++;
            end
            m_len++;
            if (!prev_sclk && SCLK) begin
                m_mosi = {m_mosi[14:0], MOSI};
                m_rises++;
            end
        end else if (!prev_ss) begin
            frame_t fr;
            fr.start = m_start;
            fr.stop  = cyc;
            fr.len   = m_len;
            fr.rises = m_rises;
            fr.mosi  = m_mosi;
            frq.push_back(fr);
        end
        prev_ss   = SS_n;
        prev_sclk = SCLK;
        if (!SS_n && m_rises < 16) MISO = m_word[15 - m_rises];
        else                       MISO = 1'b0;
    end

    int          acc = 0;
    int          rd = 0;
    logic [2:0]  exp_ch = 3'd0;
    logic [11:0] exp_res = 12'h0;
    logic [11:0] adc_map [8];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [2:0] ch, input logic [15:0] w1, input logic [15:0] w2);
        f1_word  = w1;
        f2_word  = w2;
        base     = fcnt;
        strt_cnv = 1'b1;
        chnnl    = ch;
        acc      = cyc + 1;
        exp_ch   = ch;
        exp_res  = w2[11:0];
        step();
        strt_cnv = 1'b0;
        chnnl    = 3'($urandom);
    endtask

    task automatic finish(input string tag);
        int n;
        logic [15:0] cmd;
        frame_t fa;
        frame_t fb;
        n = 0;
        while (!cnv_cmplt && n < 3000) begin
            step();
            n++;
        end
        if (!cnv_cmplt) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_lat"}, 32'(cyc - acc), 32'(LAT));
        chk({tag, "_res"}, {20'h0, res}, {20'h0, exp_res});
        cmd = {2'b00, exp_ch, 11'h000};
        if (frq.size() < rd + 2) begin
            chk({tag, "_frames"}, 32'(frq.size() - rd), 32'd2);
            return;
        end
        fa = frq[rd];
        fb = frq[rd + 1];
        rd += 2;
        chk({tag, "_f1_start"}, 32'(fa.start), 32'(acc));
        chk({tag, "_f1_len"},   32'(fa.len),   32'(FRAME_LEN));
        chk({tag, "_f2_len"},   32'(fb.len),   32'(FRAME_LEN));
        chk({tag, "_f1_rises"}, 32'(fa.rises), 32'd16);
        chk({tag, "_f2_rises"}, 32'(fb.rises), 32'd16);
        chk({tag, "_f1_mosi"},  {16'h0, fa.mosi}, {16'h0, cmd});
        chk({tag, "_f2_mosi"},  {16'h0, fb.mosi}, {16'h0, cmd});
        // clock edges strictly between SS_n rising and falling again
        chk({tag, "_gap"}, 32'(fb.start - fa.stop - 1), 32'(GAP));
    endtask

    initial begin
        int seq [6];
        logic [11:0] old_res;
        seq = '{1, 0, 4, 2, 3, 7};
        for (int i = 0; i < 8; i++) adc_map[i] = 12'($urandom);

        repeat (3) step();
        chk("rst_ss_n", {31'h0, SS_n}, 32'd1);
        chk("rst_sclk", {31'h0, SCLK}, 32'd1);
        chk("rst_mosi", {31'h0, MOSI}, 32'd0);
        chk("rst_cmplt", {31'h0, cnv_cmplt}, 32'd0);
        chk("rst_res", {20'h0, res}, 32'd0);
        rst = 1'b0;
        step();

        // channel 5, ADC answers 0xA5C
        start(3'd5, 16'h0000, 16'h0A5C);
        finish("ch5");

        // frame-1 and upper nibble of frame 2 are discarded
        start(3'd3, 16'hFFFF, 16'h0123);
        finish("discard");

        // reset mid FRAME1
        start(3'd6, 16'h1234, 16'h0FED);
        repeat (100) step();
        chk("pre_rst_ss_n", {31'h0, SS_n}, 32'd0);
        rst = 1'b1;
        step();
        chk("abort_ss_n", {31'h0, SS_n}, 32'd1);
        chk("abort_sclk", {31'h0, SCLK}, 32'd1);
        chk("abort_mosi", {31'h0, MOSI}, 32'd0);
        chk("abort_cmplt", {31'h0, cnv_cmplt}, 32'd0);
        chk("abort_res", {20'h0, res}, 32'd0);
        rst = 1'b0;
        step();
        step();
        rd = frq.size();

        // strt_cnv pulsed mid FRAME2 is ignored
        start(3'd5, 16'($urandom), 16'h0A5C);
        repeat (700) step();
        strt_cnv = 1'b1;
        chnnl    = 3'd2;
        step();
        strt_cnv = 1'b0;
        finish("ignore");

        // back-to-back from DONE
        old_res = res;
        start(3'd7, 16'($urandom), {4'hF, adc_map[7]});
        chk("b2b_cmplt_drop", {31'h0, cnv_cmplt}, 32'd0);
        chk("b2b_res_held", {20'h0, res}, {20'h0, old_res});
        repeat (600) step();
        chk("b2b_res_mid", {20'h0, res}, {20'h0, old_res});
        finish("b2b");

        // controller channel sequence
        foreach (seq[i]) begin
            repeat ($urandom_range(0, 5)) step();
            start(3'(seq[i]), 16'($urandom), {4'($urandom), adc_map[seq[i]]});
            finish($sformatf("seq%0d", i));
        end

        for (int i = 0; i < 3; i++) begin
            logic [2:0] ch;
            ch = 3'($urandom);
            repeat ($urandom_range(1, 20)) step();
            start(ch, 16'($urandom), 16'($urandom));
            finish($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
